// File: rtl/axis_tlp_rr_arbiter.sv
// rtl/axis_tlp_rr_arbiter.sv - round-robin packet arbiter merging AXI4-Stream TLP ports
module axis_tlp_rr_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int AXI_TUSER_L = 161,
    parameter int MAX_BEATS   = 256
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic [NUM_PORTS*512-1:0]         S_AXIS_TDATA,
    input  logic [NUM_PORTS*16-1:0]          S_AXIS_TKEEP,
    input  logic [NUM_PORTS*AXI_TUSER_L-1:0] S_AXIS_TUSER,
    input  logic [NUM_PORTS-1:0]             S_AXIS_TLAST,
    input  logic [NUM_PORTS-1:0]             S_AXIS_TVALID,
    output logic [NUM_PORTS-1:0]             S_AXIS_TREADY,
    output logic [511:0]                     M_AXIS_TDATA,
    output logic [15:0]                      M_AXIS_TKEEP,
    output logic [AXI_TUSER_L-1:0]           M_AXIS_TUSER,
    output logic                             M_AXIS_TLAST,
    output logic                             M_AXIS_TVALID,
    input  logic                             M_AXIS_TREADY,
    output logic [$clog2(NUM_PORTS)-1:0]     grant_idx,
    output logic                             busy,
    output logic                             error_pkt_too_long
);
    localparam int              PW        = $clog2(NUM_PORTS);
    localparam logic [15:0]     MAX_CNT   = 16'(MAX_BEATS);
    localparam logic [PW:0]     NP_W      = (PW+1)'(NUM_PORTS);
    localparam logic [PW-1:0]   LAST_PORT = PW'(NUM_PORTS - 1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t               state;
    logic [PW-1:0]        rr_ptr;
    logic [15:0]          beat_cnt;
    logic                 arb_found;
    logic [PW-1:0]        arb_sel;
    logic [PW:0]          cand;
    logic [511:0]         sel_tdata;
    logic [15:0]          sel_tkeep;
    logic [AXI_TUSER_L-1:0] sel_tuser;
    logic                 sel_tlast;
    logic                 sel_tvalid;
    logic                 slot_free;
    logic                 accept;

    // First valid port at or above rr_ptr, wrapping at NUM_PORTS.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = rr_ptr;
        cand      = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(k);
            if (cand >= NP_W) begin
                cand = cand - NP_W;
            end
            if (!arb_found && S_AXIS_TVALID[cand[PW-1:0]]) begin
                arb_found = 1'b1;
                arb_sel   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        sel_tdata  = '0;
        sel_tkeep  = '0;
        sel_tuser  = '0;
        sel_tlast  = 1'b0;
        sel_tvalid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_idx == PW'(i)) begin
                sel_tdata  = S_AXIS_TDATA[i*512 +: 512];
                sel_tkeep  = S_AXIS_TKEEP[i*16 +: 16];
                sel_tuser  = S_AXIS_TUSER[i*AXI_TUSER_L +: AXI_TUSER_L];
                sel_tlast  = S_AXIS_TLAST[i];
                sel_tvalid = S_AXIS_TVALID[i];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign slot_free = (state == LOCKED) && (!M_AXIS_TVALID || M_AXIS_TREADY);
    assign accept    = slot_free && sel_tvalid;
    assign busy      = (state == LOCKED);

    always_comb begin
        S_AXIS_TREADY = '0;
        if (slot_free) begin
            S_AXIS_TREADY[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            grant_idx          <= '0;
            beat_cnt           <= '0;
            error_pkt_too_long <= 1'b0;
            M_AXIS_TVALID      <= 1'b0;
            M_AXIS_TLAST       <= 1'b0;
            M_AXIS_TDATA       <= '0;
            M_AXIS_TKEEP       <= '0;
            M_AXIS_TUSER       <= '0;
        end else begin
            error_pkt_too_long <= accept && !sel_tlast && (beat_cnt == MAX_CNT - 16'd1);

            if (accept) begin
                M_AXIS_TVALID <= 1'b1;
                M_AXIS_TDATA  <= sel_tdata;
                M_AXIS_TKEEP  <= sel_tkeep;
                M_AXIS_TUSER  <= sel_tuser;
                M_AXIS_TLAST  <= sel_tlast;
            end else if (M_AXIS_TREADY) begin
                M_AXIS_TVALID <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant_idx <= arb_sel;
                        beat_cnt  <= '0;
                        state     <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        if (beat_cnt != MAX_CNT) begin
                            beat_cnt <= beat_cnt + 16'd1;
                        end
                        if (sel_tlast) begin
                            state  <= IDLE;
                            rr_ptr <= (grant_idx == LAST_PORT) ? '0 : grant_idx + PW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
